// File: rtl/hazard_pkg.sv
// Shared types and constants for the rv32 pipeline hazard controller.
package hazard_pkg;

  localparam int XLEN   = 32;
  localparam int RNUM_W = 5;

  typedef enum logic [1:0] {
    HZ_RUN  = 2'd0,
    HZ_LU1  = 2'd1,
    HZ_LU2  = 2'd2,
    HZ_MEMW = 2'd3
  } hz_state_t;

endpackage

// File: rtl/hazard_match.sv
// Register-number comparator: a producer hits a consumer source only when it
// actually writes and the destination is not x0.
module hazard_match #(
  parameter int W = hazard_pkg::RNUM_W
) (
  input  logic [W-1:0] wnum,
  input  logic         wr,
  input  logic [W-1:0] rnum,
  output logic         match
);

  // x0 is hard-wired zero, so writes to it never create a dependency.
  assign match = wr & (wnum != '0) & (wnum == rnum);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage rv32 core: M->EX forwarding, WB
// hang-on capture for the instruction entering EX, load-use / memory-wait
// sequencing, branch flush, and optional performance counters
// (HAZARD_PERF_EN).
//
// state   | meaning
// HZ_RUN  | normal flow, watching for load-use and branches
// HZ_LU1  | load now in M, dependent still held in ID (second bubble)
// HZ_LU2  | load in WB, dependent proceeds and captures wb_wdata
// HZ_MEMW | pipeline frozen on mem_busy, resumes the saved state
module hazard_ctrl #(
  parameter int XLEN   = hazard_pkg::XLEN,
  parameter int RNUM_W = hazard_pkg::RNUM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RNUM_W-1:0] id_reg_anum,
  input  logic [RNUM_W-1:0] id_reg_bnum,
  input  logic              id_use_ra,
  input  logic              id_use_rb,
  input  logic [RNUM_W-1:0] ex_reg_anum,
  input  logic [RNUM_W-1:0] ex_reg_bnum,
  input  logic [RNUM_W-1:0] ex_reg_wnum,
  input  logic              ex_reg_wr,
  input  logic              ex_mem_load,
  input  logic [RNUM_W-1:0] m_reg_wnum,
  input  logic              m_reg_wr,
  input  logic              m_mem_load,
  input  logic [XLEN-1:0]   m_aluresult,
  input  logic [RNUM_W-1:0] wb_reg_wnum,
  input  logic              wb_reg_wr,
  input  logic [XLEN-1:0]   wb_wdata,
  input  logic              ex_branch_taken,
  input  logic              mem_busy,
  output logic              stall_pc,
  output logic              stall_if_id,
  output logic              stall_id_ex,
  output logic              stall_ex_m,
  output logic              bubble_id_ex,
  output logic              flush_if_id,
  output logic              ex_overwrite_ra,
  output logic              ex_overwrite_rb,
  output logic [XLEN-1:0]   ex_over_data,
  output logic              id_ex_hangon_ra,
  output logic              id_ex_hangon_rb,
  output logic [XLEN-1:0]   id_ex_over_data,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
);

  import hazard_pkg::*;

  logic m_ex_ra_hit, m_ex_rb_hit;
  logic wb_id_ra_hit, wb_id_rb_hit;
  logic ex_id_ra_hit, ex_id_rb_hit;
  logic m_id_ra_hit, m_id_rb_hit;

  hazard_match #(.W(RNUM_W)) u_m_ex_ra  (.wnum(m_reg_wnum),  .wr(m_reg_wr),  .rnum(ex_reg_anum), .match(m_ex_ra_hit));
  hazard_match #(.W(RNUM_W)) u_m_ex_rb  (.wnum(m_reg_wnum),  .wr(m_reg_wr),  .rnum(ex_reg_bnum), .match(m_ex_rb_hit));
  hazard_match #(.W(RNUM_W)) u_wb_id_ra (.wnum(wb_reg_wnum), .wr(wb_reg_wr), .rnum(id_reg_anum), .match(wb_id_ra_hit));
  hazard_match #(.W(RNUM_W)) u_wb_id_rb (.wnum(wb_reg_wnum), .wr(wb_reg_wr), .rnum(id_reg_bnum), .match(wb_id_rb_hit));
  hazard_match #(.W(RNUM_W)) u_ex_id_ra (.wnum(ex_reg_wnum), .wr(ex_reg_wr), .rnum(id_reg_anum), .match(ex_id_ra_hit));
  hazard_match #(.W(RNUM_W)) u_ex_id_rb (.wnum(ex_reg_wnum), .wr(ex_reg_wr), .rnum(id_reg_bnum), .match(ex_id_rb_hit));
  hazard_match #(.W(RNUM_W)) u_m_id_ra  (.wnum(m_reg_wnum),  .wr(m_reg_wr),  .rnum(id_reg_anum), .match(m_id_ra_hit));
  hazard_match #(.W(RNUM_W)) u_m_id_rb  (.wnum(m_reg_wnum),  .wr(m_reg_wr),  .rnum(id_reg_bnum), .match(m_id_rb_hit));

  logic lu_ex, lu_m;
  assign lu_ex = ex_mem_load & ((ex_id_ra_hit & id_use_ra) | (ex_id_rb_hit & id_use_rb));
  assign lu_m  = m_mem_load  & ((m_id_ra_hit  & id_use_ra) | (m_id_rb_hit  & id_use_rb));

  hz_state_t state_q, state_d, saved_q, saved_d, run_state;
  logic      st_pc, st_if_id, st_id_ex, st_ex_m, bub, flush;

  // State and pre-freeze state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HZ_RUN;
      saved_q <= HZ_RUN;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
    end
  end

  // Next state and pipeline controls; a freeze exit resumes the saved state's rules in the same cycle.
  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    st_pc     = 1'b0;
    st_if_id  = 1'b0;
    st_id_ex  = 1'b0;
    st_ex_m   = 1'b0;
    bub       = 1'b0;
    flush     = 1'b0;
    run_state = (state_q == HZ_MEMW) ? saved_q : state_q;
    if (mem_busy) begin
      st_pc    = 1'b1;
      st_if_id = 1'b1;
      st_id_ex = 1'b1;
      st_ex_m  = 1'b1;
      saved_d  = run_state;
      state_d  = HZ_MEMW;
    end else if (ex_branch_taken) begin
      // The dependent of any pending load-use is squashed with the flush.
      flush   = 1'b1;
      bub     = 1'b1;
      state_d = HZ_RUN;
    end else begin
      state_d = HZ_RUN;
      case (run_state)
        HZ_LU1: begin
          st_pc    = 1'b1;
          st_if_id = 1'b1;
          bub      = 1'b1;
          state_d  = HZ_LU2;
        end
        HZ_LU2: state_d = HZ_RUN;
        default: begin
          if (lu_ex || lu_m) begin
            st_pc    = 1'b1;
            st_if_id = 1'b1;
            bub      = 1'b1;
          end
          if (lu_ex) state_d = HZ_LU1;
        end
      endcase
    end
  end

  assign stall_pc     = st_pc & rst;
  assign stall_if_id  = st_if_id & rst;
  assign stall_id_ex  = st_id_ex & rst;
  assign stall_ex_m   = st_ex_m & rst;
  assign bubble_id_ex = bub & rst;
  assign flush_if_id  = flush & rst;

  assign ex_overwrite_ra = rst & m_ex_ra_hit & ~m_mem_load;
  assign ex_overwrite_rb = rst & m_ex_rb_hit & ~m_mem_load;
  assign ex_over_data    = m_aluresult;

  logic            raw_ra, raw_rb, frozen;
  logic [XLEN-1:0] raw_data;
  logic            hold_ra_q, hold_rb_q;
  logic [XLEN-1:0] hold_data_q;

  assign raw_ra   = wb_id_ra_hit & id_use_ra & ~bubble_id_ex;
  assign raw_rb   = wb_id_rb_hit & id_use_rb & ~bubble_id_ex;
  assign raw_data = bubble_id_ex ? '0 : wb_wdata;
  assign frozen   = (state_q == HZ_MEMW);

  // Keep the last hang-on seen before a freeze so EX keeps resampling it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_ra_q   <= 1'b0;
      hold_rb_q   <= 1'b0;
      hold_data_q <= '0;
    end else if (!frozen) begin
      hold_ra_q   <= raw_ra;
      hold_rb_q   <= raw_rb;
      hold_data_q <= raw_data;
    end
  end

  assign id_ex_hangon_ra = rst & (frozen ? hold_ra_q : raw_ra);
  assign id_ex_hangon_rb = rst & (frozen ? hold_rb_q : raw_rb);
  assign id_ex_over_data = frozen ? hold_data_q : raw_data;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_pc)    stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_if_id) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic,
// expectations from a cycle-level model of the pipeline hazard rules.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  id_reg_anum, id_reg_bnum, ex_reg_anum, ex_reg_bnum, ex_reg_wnum, m_reg_wnum, wb_reg_wnum;
  logic        id_use_ra, id_use_rb, ex_reg_wr, ex_mem_load, m_reg_wr, m_mem_load, wb_reg_wr;
  logic        ex_branch_taken, mem_busy;
  logic [31:0] m_aluresult, wb_wdata;
  logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_m, bubble_id_ex, flush_if_id;
  logic        ex_overwrite_ra, ex_overwrite_rb, id_ex_hangon_ra, id_ex_hangon_rb;
  logic [31:0] ex_over_data, id_ex_over_data, perf_stall_cnt, perf_flush_cnt;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_reg_anum(id_reg_anum), .id_reg_bnum(id_reg_bnum),
    .id_use_ra(id_use_ra), .id_use_rb(id_use_rb),
    .ex_reg_anum(ex_reg_anum), .ex_reg_bnum(ex_reg_bnum),
    .ex_reg_wnum(ex_reg_wnum), .ex_reg_wr(ex_reg_wr), .ex_mem_load(ex_mem_load),
    .m_reg_wnum(m_reg_wnum), .m_reg_wr(m_reg_wr), .m_mem_load(m_mem_load), .m_aluresult(m_aluresult),
    .wb_reg_wnum(wb_reg_wnum), .wb_reg_wr(wb_reg_wr), .wb_wdata(wb_wdata),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex), .stall_ex_m(stall_ex_m),
    .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
    .ex_overwrite_ra(ex_overwrite_ra), .ex_overwrite_rb(ex_overwrite_rb), .ex_over_data(ex_over_data),
    .id_ex_hangon_ra(id_ex_hangon_ra), .id_ex_hangon_rb(id_ex_hangon_rb), .id_ex_over_data(id_ex_over_data),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  ctl;     // stall_pc, stall_if_id, stall_id_ex, stall_ex_m, bubble, flush
    logic        ow_ra;
    logic        ow_rb;
    logic [31:0] ow_data;
    logic        ho_ra;
    logic        ho_rb;
    logic [31:0] ho_data;
    logic [31:0] pcnt;
    logic [31:0] fcnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: how many more cycles the dependent of a load waits
  // (2 = one more stall then release, 1 = release cycle), whether last cycle
  // was a memory freeze, the captured hang-on, and event totals.
  int          lu_left = 0;
  bit          was_frozen = 0;
  bit          hold_ra = 0, hold_rb = 0;
  logic [31:0] hold_data = '0;
  logic [31:0] cnt_stall = '0, cnt_flush = '0;

  function automatic bit hit(logic [4:0] w, logic we, logic [4:0] r);
    return we && (w != 5'd0) && (w == r);
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    lu_left = 0; was_frozen = 0; hold_ra = 0; hold_rb = 0; hold_data = '0;
    cnt_stall = '0; cnt_flush = '0;
  endtask

  // Compute the expected outputs for the inputs now applied, then advance the model one clock.
  task automatic push_expect();
    exp_t e;
    bit   pc, ifid, idex, exm, bub, fl, need_ex, need_m, raw_a, raw_b;
    int   next_left;
    logic [31:0] raw_d;
    pc = 0; ifid = 0; idex = 0; exm = 0; bub = 0; fl = 0;
    next_left = lu_left;
    need_ex = ex_mem_load && ((id_use_ra && hit(ex_reg_wnum, ex_reg_wr, id_reg_anum)) ||
                              (id_use_rb && hit(ex_reg_wnum, ex_reg_wr, id_reg_bnum)));
    need_m  = m_mem_load  && ((id_use_ra && hit(m_reg_wnum, m_reg_wr, id_reg_anum)) ||
                              (id_use_rb && hit(m_reg_wnum, m_reg_wr, id_reg_bnum)));
    if (mem_busy) begin
      pc = 1; ifid = 1; idex = 1; exm = 1;
    end else if (ex_branch_taken) begin
      fl = 1; bub = 1; next_left = 0;
    end else if (lu_left == 2) begin
      pc = 1; ifid = 1; bub = 1; next_left = 1;
    end else if (lu_left == 1) begin
      next_left = 0;
    end else if (need_ex) begin
      pc = 1; ifid = 1; bub = 1; next_left = 2;
    end else if (need_m) begin
      pc = 1; ifid = 1; bub = 1;
    end
    raw_a = !bub && id_use_ra && hit(wb_reg_wnum, wb_reg_wr, id_reg_anum);
    raw_b = !bub && id_use_rb && hit(wb_reg_wnum, wb_reg_wr, id_reg_bnum);
    raw_d = bub ? 32'd0 : wb_wdata;
    e.ctl     = {pc, ifid, idex, exm, bub, fl};
    e.ow_ra   = !m_mem_load && hit(m_reg_wnum, m_reg_wr, ex_reg_anum);
    e.ow_rb   = !m_mem_load && hit(m_reg_wnum, m_reg_wr, ex_reg_bnum);
    e.ow_data = m_aluresult;
    e.ho_ra   = was_frozen ? hold_ra : raw_a;
    e.ho_rb   = was_frozen ? hold_rb : raw_b;
    e.ho_data = was_frozen ? hold_data : raw_d;
`ifdef HAZARD_PERF_EN
    e.pcnt = cnt_stall;
    e.fcnt = cnt_flush;
`else
    e.pcnt = '0;
    e.fcnt = '0;
`endif
    sb.push_back(e);
    if (!was_frozen) begin
      hold_ra = raw_a; hold_rb = raw_b; hold_data = raw_d;
    end
    was_frozen = mem_busy;
    cnt_stall  = cnt_stall + {31'd0, pc};
    cnt_flush  = cnt_flush + {31'd0, fl};
    lu_left    = next_left;
  endtask

  // Monitor: every cycle with a pending expectation, compare DUT outputs mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ctl", {122'd0, stall_pc, stall_if_id, stall_id_ex, stall_ex_m, bubble_id_ex, flush_if_id},
              {122'd0, e.ctl});
        check("fwd", {60'd0, ex_overwrite_ra, ex_overwrite_rb, ex_over_data, id_ex_hangon_ra, id_ex_hangon_rb, id_ex_over_data},
              {60'd0, e.ow_ra, e.ow_rb, e.ow_data, e.ho_ra, e.ho_rb, e.ho_data});
        check("perf", {64'd0, perf_stall_cnt, perf_flush_cnt}, {64'd0, e.pcnt, e.fcnt});
      end
    end
  end

  task automatic set_idle();
    id_reg_anum = 0; id_reg_bnum = 0; id_use_ra = 0; id_use_rb = 0;
    ex_reg_anum = 0; ex_reg_bnum = 0; ex_reg_wnum = 0; ex_reg_wr = 0; ex_mem_load = 0;
    m_reg_wnum = 0; m_reg_wr = 0; m_mem_load = 0; m_aluresult = 0;
    wb_reg_wnum = 0; wb_reg_wr = 0; wb_wdata = 0;
    ex_branch_taken = 0; mem_busy = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // lw x6 in EX, add in ID reading x6 as rb.
  task automatic load_use_x6();
    set_idle();
    ex_reg_wnum = 6; ex_reg_wr = 1; ex_mem_load = 1;
    id_reg_anum = 1; id_reg_bnum = 6; id_use_ra = 1; id_use_rb = 1;
  endtask

  task automatic load_in_m_x6();
    set_idle();
    m_reg_wnum = 6; m_reg_wr = 1; m_mem_load = 1;
    id_reg_anum = 1; id_reg_bnum = 6; id_use_ra = 1; id_use_rb = 1;
  endtask

  task automatic load_in_wb_x6(logic [31:0] d);
    set_idle();
    wb_reg_wnum = 6; wb_reg_wr = 1; wb_wdata = d;
    id_reg_anum = 1; id_reg_bnum = 6; id_use_ra = 1; id_use_rb = 1;
  endtask

  initial begin
    set_idle();
    model_reset();
    next_cycle();
    next_cycle();
    rst = 1'b1;
    push_expect();                      // idle after reset

    // M ALU writes x5 = 0x1234, EX reads x5 as ra.
    next_cycle(); set_idle();
    m_reg_wnum = 5; m_reg_wr = 1; m_aluresult = 32'h1234; ex_reg_anum = 5; ex_reg_bnum = 7;
    push_expect();

    // Load-use: two stalled cycles then the hang-on picks up 0xCAFE.
    next_cycle(); load_use_x6();        push_expect();
    next_cycle(); load_in_m_x6();       push_expect();
    next_cycle(); load_in_wb_x6(32'hCAFE); push_expect();
    next_cycle(); set_idle();           push_expect();

    // Branch taken while in the second load-use bubble.
    next_cycle(); load_use_x6();        push_expect();
    next_cycle(); load_in_m_x6(); ex_branch_taken = 1; push_expect();
    next_cycle(); set_idle();           push_expect();

    // Memory freeze for 3 cycles during the release cycle carrying 0xBEEF.
    next_cycle(); load_use_x6();        push_expect();
    next_cycle(); load_in_m_x6();       push_expect();
    next_cycle(); load_in_wb_x6(32'hBEEF); mem_busy = 1; push_expect();
    for (int i = 0; i < 2; i++) begin
      next_cycle(); load_in_wb_x6(32'h0BAD_0000 + i); id_reg_bnum = 9; mem_busy = 1; push_expect();
    end
    next_cycle(); load_in_wb_x6(32'hBEEF); push_expect();
    next_cycle(); set_idle();           push_expect();

    // Writes to x0 never match.
    next_cycle(); set_idle();
    m_reg_wnum = 0; m_reg_wr = 1; m_aluresult = 32'h55; ex_reg_anum = 0; ex_reg_bnum = 0;
    wb_reg_wnum = 0; wb_reg_wr = 1; wb_wdata = 32'h77; id_use_ra = 1; id_use_rb = 1;
    ex_reg_wnum = 0; ex_reg_wr = 1; ex_mem_load = 1;
    push_expect();

    // Reset in the middle of a load-use sequence.
    next_cycle(); load_use_x6();        push_expect();
    next_cycle(); load_in_m_x6(); m_reg_wr = 1; ex_reg_anum = 6; m_aluresult = 32'h99;
    rst = 1'b0;
    #1;
    check("rst_outs", {120'd0, stall_pc, stall_if_id, stall_id_ex, stall_ex_m, bubble_id_ex, flush_if_id,
                       ex_overwrite_ra, ex_overwrite_rb, id_ex_hangon_ra, id_ex_hangon_rb}, 128'd0);
    check("rst_ovdata", {96'd0, ex_over_data}, {96'd0, 32'h99});
    check("rst_perf", {64'd0, perf_stall_cnt, perf_flush_cnt}, 128'd0);
    model_reset();
    next_cycle(); rst = 1'b1; set_idle(); push_expect();

    // Five frozen cycles, then idle: stall counter reaches 5 when enabled.
    for (int i = 0; i < 5; i++) begin
      next_cycle(); set_idle(); mem_busy = 1; push_expect();
    end
    next_cycle(); set_idle(); push_expect();
    next_cycle(); set_idle(); push_expect();

    // Random traffic over a small register range to provoke frequent matches.
    for (int i = 0; i < 1500; i++) begin
      next_cycle();
      id_reg_anum = 5'($urandom_range(0, 3)); id_reg_bnum = 5'($urandom_range(0, 3));
      id_use_ra = 1'($urandom); id_use_rb = 1'($urandom);
      ex_reg_anum = 5'($urandom_range(0, 3)); ex_reg_bnum = 5'($urandom_range(0, 3));
      ex_reg_wnum = 5'($urandom_range(0, 3)); ex_reg_wr = ($urandom_range(0, 3) != 0);
      ex_mem_load = 1'($urandom);
      m_reg_wnum = 5'($urandom_range(0, 3)); m_reg_wr = ($urandom_range(0, 3) != 0);
      m_mem_load = 1'($urandom); m_aluresult = $urandom;
      wb_reg_wnum = 5'($urandom_range(0, 3)); wb_reg_wr = ($urandom_range(0, 3) != 0);
      wb_wdata = $urandom;
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      mem_busy = ($urandom_range(0, 5) == 0);
      push_expect();
    end

    next_cycle(); set_idle();
    @(negedge clk);
    #1;
    check("sb_drained", {96'd0, 32'(sb.size())}, 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
